// File: rtl/little_mem_if.sv
// rtl/little_mem_if.sv - little-cpu memory bus bundle; mem_fault present only with LITTLE_MEM_FAULT_EN
interface little_mem_if;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_valid;
  logic [31:0] mem_rdata;
`ifdef LITTLE_MEM_FAULT_EN
  logic        mem_fault;

  modport master (
    output mem_ready, mem_addr, mem_wdata, mem_wstrb,
    input  mem_valid, mem_rdata, mem_fault
  );
  modport slave (
    input  mem_ready, mem_addr, mem_wdata, mem_wstrb,
    output mem_valid, mem_rdata, mem_fault
  );
`else
  modport master (
    output mem_ready, mem_addr, mem_wdata, mem_wstrb,
    input  mem_valid, mem_rdata
  );
  modport slave (
    input  mem_ready, mem_addr, mem_wdata, mem_wstrb,
    output mem_valid, mem_rdata
  );
`endif
endinterface

// File: rtl/little_mem.sv
// rtl/little_mem.sv - single-port wait-stated memory responder; LITTLE_MEM_FAULT_EN adds mem_fault
module little_mem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  little_mem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              valid_q;
  logic [31:0]       rdata_q;

  logic [31:0]       mem_array [DEPTH_WORDS];

  logic [31:0]       offset;
  logic              in_range;
  logic [IDX_W-1:0]  index;
  logic              is_write;
  logic              access;
  logic              access_fault;
  logic              mem_we;

`ifdef LITTLE_MEM_FAULT_EN
  logic              fault_q;

  function automatic logic strobe_legal(input logic [3:0] s);
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction
`endif

  // Address decode works only on captured values so input changes after capture are ignored.
  always_comb begin
    offset   = addr_q - BASE_ADDR;
    in_range = (addr_q >= BASE_ADDR) && (offset[31:IDX_W+2] == '0);
    index    = offset[IDX_W+1:2];
    is_write = |wstrb_q;
    access   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
`ifdef LITTLE_MEM_FAULT_EN
    access_fault = !in_range || (is_write && !strobe_legal(wstrb_q));
`else
    access_fault = !in_range;
`endif
    // Reset on the access edge drops the pending write.
    mem_we = access && !reset && is_write && !access_fault;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.mem_ready) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
`ifdef LITTLE_MEM_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= access;
      rdata_q <= (access && !is_write && in_range) ? mem_array[index] : '0;
`ifdef LITTLE_MEM_FAULT_EN
      fault_q <= access && access_fault;
`endif
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_ready) begin
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            wstrb_q <= bus.mem_wstrb;
            cnt_q   <= 4'(LATENCY);
          end
        end
        ST_WAIT: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Array has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem_array[index][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.mem_valid = valid_q;
  assign bus.mem_rdata = rdata_q;
`ifdef LITTLE_MEM_FAULT_EN
  assign bus.mem_fault = fault_q;
`endif

endmodule

// File: tb/tb_little_mem.sv
// tb/tb_little_mem.sv - scoreboard bench for little_mem; two instances at LATENCY 2 and 0
module tb_little_mem;

  localparam int          L2     = 2;
  localparam int          D2     = 64;
  localparam logic [31:0] BASE2  = 32'h0000_0000;
  localparam int          L0     = 0;
  localparam int          D0     = 16;
  localparam logic [31:0] BASE0  = 32'h0000_1000;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t q2[$];
  exp_t q0[$];
  exp_t e2;
  exp_t e0;
  logic [31:0] model [D2];

  little_mem_if bus2 ();
  little_mem_if bus0 ();

  little_mem #(.DEPTH_WORDS(D2), .LATENCY(L2), .BASE_ADDR(BASE2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  little_mem #(.DEPTH_WORDS(D0), .LATENCY(L0), .BASE_ADDR(BASE0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (ws[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic exp_fault(input logic f);
`ifdef LITTLE_MEM_FAULT_EN
    return f;
`else
    return 1'b0 & f;
`endif
  endfunction

  function automatic logic sel_valid(input int sel);
    return (sel == 0) ? bus0.mem_valid : bus2.mem_valid;
  endfunction

  task automatic set_req(input int sel, input logic rdy, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    if (sel == 0) begin
      bus0.mem_ready = rdy; bus0.mem_addr = a; bus0.mem_wdata = wd; bus0.mem_wstrb = ws;
    end else begin
      bus2.mem_ready = rdy; bus2.mem_addr = a; bus2.mem_wdata = wd; bus2.mem_wstrb = ws;
    end
  endtask

  // Holds the request until the response is seen, as the core would.
  task automatic request(input int sel, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] rd, input logic f);
    exp_t e;
    int   n;
    @(negedge clk);
    set_req(sel, 1'b1, a, wd, ws);
    @(negedge clk);
    e.rdata = rd;
    e.fault = exp_fault(f);
    e.due   = cyc + 1 + ((sel == 0) ? L0 : L2);
    if (sel == 0) q0.push_back(e); else q2.push_back(e);
    n = 0;
    while (!sel_valid(sel) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!sel_valid(sel)) check("response_timeout", 32'd0, 32'd1);
    set_req(sel, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  always @(negedge clk) begin
    if (!reset && bus2.mem_valid) begin
      if (q2.size() == 0) check("dut2_spurious_valid", 32'd1, 32'd0);
      else begin
        e2 = q2.pop_front();
        check("dut2_rdata", bus2.mem_rdata, e2.rdata);
        check("dut2_latency_cycle", 32'(cyc), 32'(e2.due));
`ifdef LITTLE_MEM_FAULT_EN
        check("dut2_fault", 32'(bus2.mem_fault), 32'(e2.fault));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus0.mem_valid) begin
      if (q0.size() == 0) check("dut0_spurious_valid", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("dut0_rdata", bus0.mem_rdata, e0.rdata);
        check("dut0_latency_cycle", 32'(cyc), 32'(e0.due));
`ifdef LITTLE_MEM_FAULT_EN
        check("dut0_fault", 32'(bus0.mem_fault), 32'(e0.fault));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [3:0]  legal [7];
    int          idx;
    int          base;
    int          n;
    exp_t        e;

    legal[0] = 4'b0001; legal[1] = 4'b0010; legal[2] = 4'b0100; legal[3] = 4'b1000;
    legal[4] = 4'b0011; legal[5] = 4'b1100; legal[6] = 4'b1111;
    cyc = 0;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(2, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_valid", 32'(bus2.mem_valid), 32'd0);
      check("idle_rdata", bus2.mem_rdata, 32'd0);
      check("idle_valid0", 32'(bus0.mem_valid), 32'd0);
    end

    request(2, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    model[4] = 32'hDEADBEEF;
    request(2, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    request(2, 32'h10, 32'h0000AA00, 4'b0010, 32'h0, 1'b0);
    request(2, 32'h10, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0);
    request(2, 32'h10, 32'h12340000, 4'b1100, 32'h0, 1'b0);
    request(2, 32'h10, 32'h0, 4'h0, 32'h1234AAEF, 1'b0);
    model[4] = 32'h1234AAEF;

    // Out-of-range write must not alias onto word 0.
    request(2, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    model[0] = 32'hCAFEF00D;
    request(2, BASE2 + D2 * 4, 32'h12345678, 4'hF, 32'h0, 1'b1);
    request(2, BASE2 + D2 * 4, 32'h0, 4'h0, 32'h0, 1'b1);
    request(2, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

    request(2, 32'h10, 32'hA5A5A5A5, 4'b0101, 32'h0, 1'b1);
`ifndef LITTLE_MEM_FAULT_EN
    model[4] = merge(model[4], 32'hA5A5A5A5, 4'b0101);
`endif
    request(2, 32'h10, 32'h0, 4'h0, model[4], 1'b0);

    for (int k = 0; k < 4; k++) begin
      idx = 8 + k * 9;
      wd  = $urandom;
      ws  = legal[$urandom_range(0, 6)];
      model[idx] = merge(32'h0, 32'hFFFF_FFFF, 4'hF) & 32'h0;
      request(2, 32'(idx * 4), 32'h0, 4'hF, 32'h0, 1'b0);
      request(2, 32'(idx * 4), wd, ws, 32'h0, 1'b0);
      model[idx] = merge(model[idx], wd, ws);
      request(2, 32'(idx * 4) | 32'h3, 32'h0, 4'h0, model[idx], 1'b0);
    end

    // Reset during WAIT drops the captured write.
    @(negedge clk);
    set_req(2, 1'b1, 32'h10, 32'h55555555, 4'hF);
    @(negedge clk);
    set_req(2, 1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    request(2, 32'h10, 32'h0, 4'h0, model[4], 1'b0);

    for (int k = 0; k < 4; k++)
      request(0, BASE0 + 32'(k * 4), 32'h1111_0000 + 32'(k * 32'h0101), 4'hF, 32'h0, 1'b0);

    // Four reads with mem_ready held; address switched during RESP, which must be ignored.
    @(negedge clk);
    set_req(0, 1'b1, BASE0, 32'h0, 4'h0);
    @(negedge clk);
    base = cyc;
    for (int k = 0; k < 4; k++) begin
      e.rdata = 32'h1111_0000 + 32'(k * 32'h0101);
      e.fault = 1'b0;
      e.due   = base + 1 + (L0 + 3) * k;
      q0.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!bus0.mem_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!bus0.mem_valid) check("b2b_timeout", 32'd0, 32'd1);
      if (k < 3) set_req(0, 1'b1, BASE0 + 32'((k + 1) * 4), 32'h0, 4'h0);
      else set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
    end
    repeat (6) @(negedge clk);

    request(0, BASE0 + D0 * 4, 32'h0, 4'h0, 32'h0, 1'b1);
    request(0, BASE0 - 32'd4, 32'h0, 4'h0, 32'h0, 1'b1);
    request(0, BASE0 + 32'd8, 32'h0, 4'h0, 32'h1111_0202, 1'b0);

    repeat (5) @(negedge clk);
    check("q2_drained", 32'(q2.size()), 32'd0);
    check("q0_drained", 32'(q0.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/little_mem.md
# little_mem

Single-port word-addressed memory responder for the little-cpu memory bus, sitting on the far side of the core's `mem_ready`/`mem_valid` handshake. It accepts one read or byte-strobed write request at a time, inserts a programmable number of wait states, and returns one response pulse carrying read data. It serves as the instruction/data memory for simulation and small FPGA builds, and its wait states exercise pipeline stalls.

## Interface

Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 1: wait cycles inserted between request capture and response; 0 to 15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `mem_ready` in 1: request from the core; held with address, data and strobe until `mem_valid` is seen.
- `mem_addr` in 32: byte address; bits [1:0] are ignored for word indexing.
- `mem_wdata` in 32: write data, byte lanes aligned to the address.
- `mem_wstrb` in 4: byte write enables; 4'b0000 means read.
- `mem_valid` out 1: response strobe, one cycle per request.
- `mem_rdata` out 32: read data, valid only while `mem_valid`=1.
- `mem_fault` out 1: present only with `LITTLE_MEM_FAULT_EN`.

## Operation

- FSM states are IDLE, WAIT and RESP.
- **IDLE:**
  - When `mem_ready`=1, capture the address, wdata and wstrb into registers.
  - Load the wait counter with `LATENCY`.
  - Go to WAIT.
- **WAIT:**
  - If the counter is nonzero, decrement it.
  - If the counter is 0, perform the access on this edge and go to RESP.
- **Access** (uses captured values only):
  - Word index = (addr − `BASE_ADDR`) >> 2.
  - In range means index < `DEPTH_WORDS` and addr ≥ `BASE_ADDR`.
  - Read (wstrb=0): `mem_rdata` is loaded with array[index].
  - Write: each lane i with wstrb[i]=1 writes wdata[8i+7:8i]. `mem_rdata` is loaded with 0.
  - Out of range: no array update and `mem_rdata`=0.
- **RESP:**
  - `mem_valid`=1 for exactly this cycle; then go to IDLE.
  - `mem_ready` still being high during RESP is not a new request. A new request is captured no earlier than the following IDLE cycle.
- Requests are never accepted outside IDLE. Changes on the request inputs during WAIT or RESP are ignored.
- If `mem_ready` drops before the response, that is a protocol violation. The block completes the captured access anyway.
- `mem_addr` bits above the index range are checked only by the range test; there is no aliasing.
- Array contents are not initialised by reset. The simulation preload is by `$readmemh` under a plusarg, outside this spec's scope.

## Timing

- Reset values: FSM=IDLE, `mem_valid`=0, `mem_rdata`=0, `mem_fault`=0, counter=0. Array contents are retained.
- Reset asserted in WAIT or RESP aborts the request. A pending write is dropped if reset arrives before the WAIT→RESP edge.
- Latency: request sampled at edge N, `mem_valid` high in cycle N+1+`LATENCY`.
- Throughput: one request per `LATENCY`+3 cycles with `mem_ready` held continuously.
- Write visibility: a read captured after a write's RESP cycle returns the new data.
- `mem_rdata` and `mem_valid` are registered outputs with no combinational path from the inputs.

## Configuration

- **`LITTLE_MEM_FAULT_EN` defined:**
  - Adds a `mem_fault` output. It is registered and asserted only in the RESP cycle alongside `mem_valid`.
  - Asserted when the access was out of range.
  - Also asserted when a write used an illegal strobe. Legal strobes are 0001, 0010, 0100, 1000, 0011, 1100 and 1111.
  - A faulting write does not update the array.
- **Undefined:**
  - No `mem_fault` port.
  - Out-of-range accesses return 0 and drop writes silently.
  - Any nonzero strobe writes exactly the enabled lanes.

## Test plan

- Reset, then idle 5 cycles → `mem_valid`=0, `mem_rdata`=0 throughout.
- With `LATENCY`=2: write 32'hDEADBEEF to 0x10 with strobe 1111, then read 0x10 → `mem_valid` 3 cycles after each capture; read returns 32'hDEADBEEF.
- Byte write 32'h0000_AA00 with strobe 0010 at 0x10 over DEADBEEF, then read → 32'hDEADAAEF; halfword 1100 with 32'h1234_0000 → 32'h1234AAEF.
- `mem_ready` held high across four back-to-back reads at `LATENCY`=0 → exactly four single-cycle `mem_valid` pulses, spaced 3 cycles apart.
- Read at `BASE_ADDR`+`DEPTH_WORDS`*4 → `mem_rdata`=0; with `LITTLE_MEM_FAULT_EN`, `mem_fault`=1 in the same cycle as `mem_valid`, and strobe 0101 also faults with the array unchanged.
- Write request, then `reset` asserted for 1 cycle during WAIT → no `mem_valid`; a subsequent read returns the old word.
